// File: rtl/sample_dot_acc_if.sv
// rtl/sample_dot_acc_if.sv - product input and result output handshake bundle for sample_dot_acc
interface sample_dot_acc_if #(
    parameter int DIN_WIDTH  = 13,
    parameter int DOUT_WIDTH = 13
);
    logic [DIN_WIDTH-1:0]  prod_data;
    logic                  prod_valid;
    logic                  prod_ready;
    logic [DOUT_WIDTH-1:0] acc_dout;
    logic                  acc_valid;
    logic                  acc_ready;
    logic                  acc_ovf;
    logic                  busy;

    modport master (
        output prod_data, prod_valid, acc_ready,
        input  prod_ready, acc_dout, acc_valid, acc_ovf, busy
    );

    modport slave (
        input  prod_data, prod_valid, acc_ready,
        output prod_ready, acc_dout, acc_valid, acc_ovf, busy
    );
endinterface

// File: rtl/sample_dot_acc.sv
// rtl/sample_dot_acc.sv - streaming dot-product accumulator with rescale and narrowing
// Define SAMPLE_DOT_ACC_SAT_EN to clamp out-of-range results; otherwise they wrap.
module sample_dot_acc #(
    parameter int DIN_WIDTH  = 13,
    parameter int ACC_WIDTH  = 24,
    parameter int DOUT_WIDTH = 13,
    parameter int LEN        = 16,
    parameter int SHIFT      = 4
) (
    input  logic ap_clk,
    input  logic ap_rst,
    sample_dot_acc_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    logic [0:0]                   state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
    logic                         ovf_q, ovf_d;

    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [ACC_WIDTH-DOUT_WIDTH:0] hi_bits;
    logic                         in_range;
    logic                         last_beat;
    logic [DOUT_WIDTH-1:0]        narrowed;

    always_comb begin
        sum       = acc_q + {{(ACC_WIDTH-DIN_WIDTH){bus.prod_data[DIN_WIDTH-1]}}, bus.prod_data};
        shifted   = sum >>> SHIFT;
        // s fits in DOUT_WIDTH bits when every bit above the result sign bit matches it
        hi_bits   = shifted[ACC_WIDTH-1:DOUT_WIDTH-1];
        in_range  = (&hi_bits) | ~(|hi_bits);
        last_beat = (cnt_q == CNT_W'(LEN-1));
`ifdef SAMPLE_DOT_ACC_SAT_EN
        if (in_range)
            narrowed = shifted[DOUT_WIDTH-1:0];
        else if (shifted[ACC_WIDTH-1])
            narrowed = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
        else
            narrowed = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
`else
        narrowed = shifted[DOUT_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (bus.prod_valid) begin
                    if (last_beat) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        dout_d  = narrowed;
                        ovf_d   = ~in_range;
                        state_d = ST_OUT;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (bus.acc_ready)
                    state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    // prod_ready is a pure function of state so it never depends on acc_ready
    assign bus.prod_ready = (state_q == ST_ACC);
    assign bus.acc_valid  = (state_q == ST_OUT);
    assign bus.acc_dout   = dout_q;
    assign bus.acc_ovf    = ovf_q;
    assign bus.busy       = (state_q == ST_OUT) || (cnt_q != '0);
endmodule

// File: tb/tb_sample_dot_acc.sv
// tb/tb_sample_dot_acc.sv - randomized self-checking bench for sample_dot_acc against an arithmetic model
module tb_sample_dot_acc;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int fails  = 0;

    localparam int NDUT = 3;
    int lens  [NDUT] = '{4, 16, 1};
    int shifts[NDUT] = '{0, 4, 0};

    logic signed [12:0] pdata [NDUT];
    logic               pvalid[NDUT];
    logic               aready[NDUT];
    logic               pready[NDUT];
    logic signed [12:0] dout  [NDUT];
    logic               avalid[NDUT];
    logic               aovf  [NDUT];
    logic               busyw [NDUT];

    sample_dot_acc_if #(.DIN_WIDTH(13), .DOUT_WIDTH(13)) if_a ();
    sample_dot_acc_if #(.DIN_WIDTH(13), .DOUT_WIDTH(13)) if_b ();
    sample_dot_acc_if #(.DIN_WIDTH(13), .DOUT_WIDTH(13)) if_c ();

    sample_dot_acc #(.LEN(4),  .SHIFT(0)) u_dut_a (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if_a.slave));
    sample_dot_acc #(.LEN(16), .SHIFT(4)) u_dut_b (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if_b.slave));
    sample_dot_acc #(.LEN(1),  .SHIFT(0)) u_dut_c (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if_c.slave));

    assign if_a.prod_data = pdata[0];  assign if_a.prod_valid = pvalid[0];  assign if_a.acc_ready = aready[0];
    assign if_b.prod_data = pdata[1];  assign if_b.prod_valid = pvalid[1];  assign if_b.acc_ready = aready[1];
    assign if_c.prod_data = pdata[2];  assign if_c.prod_valid = pvalid[2];  assign if_c.acc_ready = aready[2];
    assign pready[0] = if_a.prod_ready; assign dout[0] = if_a.acc_dout; assign avalid[0] = if_a.acc_valid;
    assign aovf[0]   = if_a.acc_ovf;    assign busyw[0] = if_a.busy;
    assign pready[1] = if_b.prod_ready; assign dout[1] = if_b.acc_dout; assign avalid[1] = if_b.acc_valid;
    assign aovf[1]   = if_b.acc_ovf;    assign busyw[1] = if_b.busy;
    assign pready[2] = if_c.prod_ready; assign dout[2] = if_c.acc_dout; assign avalid[2] = if_c.acc_valid;
    assign aovf[2]   = if_c.acc_ovf;    assign busyw[2] = if_c.busy;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: floor division by 2^shift, then clamp or two's-complement wrap to 13 bits
    function automatic void model(input longint total, input int shift,
                                  output longint exp_dout, output longint exp_ovf);
        longint d, s, w;
        d = longint'(1) << shift;
        if (total >= 0) s = total / d;
        else            s = -((-total + d - 1) / d);
        exp_ovf = (s < -4096 || s > 4095) ? 1 : 0;
        w = ((s % 8192) + 8192) % 8192;
        if (w >= 4096) w = w - 8192;
`ifdef SAMPLE_DOT_ACC_SAT_EN
        if (s > 4095)       exp_dout = 4095;
        else if (s < -4096) exp_dout = -4096;
        else                exp_dout = s;
`else
        exp_dout = w;
`endif
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic beat(input int k, input int val);
        int guard = 0;
        pvalid[k] = 1'b1;
        pdata[k]  = 13'(val);
        while (!pready[k] && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check($sformatf("ready_timeout[%0d]", k), 0, 1);
        step();
        pvalid[k] = 1'b0;
    endtask

    task automatic run_vec(input int k, input int vals[$], input bit gaps, input int stall,
                           input string tag);
        longint total = 0;
        longint exp_dout, exp_ovf;
        logic signed [12:0] held;
        aready[k] = 1'b0;
        foreach (vals[i]) begin
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                for (int j = 0; j < idle; j++) step();
            end
            beat(k, vals[i]);
            total += vals[i];
        end
        model(total, shifts[k], exp_dout, exp_ovf);
        check({tag, ".valid_lat"}, avalid[k], 1);
        check({tag, ".dout"}, dout[k], exp_dout);
        check({tag, ".ovf"}, aovf[k], exp_ovf);
        check({tag, ".busy"}, busyw[k], 1);
        held = dout[k];
        // offered beats during a stall must be refused, not folded into the next vector
        pvalid[k] = (stall > 0);
        pdata[k]  = 13'sd1000;
        for (int j = 0; j < stall; j++) begin
            step();
            check({tag, ".stall_dout"}, dout[k], held);
            check({tag, ".stall_ready"}, pready[k], 0);
        end
        pvalid[k] = 1'b0;
        aready[k] = 1'b1;
        step();
        aready[k] = 1'b0;
        check({tag, ".valid_drop"}, avalid[k], 0);
    endtask

    task automatic rand_vec(input int k, input int lo, input int hi, output int vals[$]);
        vals = {};
        for (int i = 0; i < lens[k]; i++)
            vals.push_back(int'($urandom_range(hi - lo, 0)) + lo);
    endtask

    initial begin
        int v[$];
        for (int k = 0; k < NDUT; k++) begin
            pdata[k] = '0; pvalid[k] = 1'b0; aready[k] = 1'b0;
        end
        repeat (3) step();
        ap_rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst.ready[%0d]", k), pready[k], 1);
            check($sformatf("rst.valid[%0d]", k), avalid[k], 0);
            check($sformatf("rst.dout[%0d]", k), dout[k], 0);
            check($sformatf("rst.ovf[%0d]", k), aovf[k], 0);
            check($sformatf("rst.busy[%0d]", k), busyw[k], 0);
        end

        run_vec(0, '{100, 200, -50, 25}, 1'b0, 0, "basic");
        run_vec(0, '{4095, 4095, 4095, 4095}, 1'b0, 0, "pos_ovf");
        run_vec(0, '{-4096, -4096, -4096, -4096}, 1'b0, 0, "neg_ovf");

        v = {-17};
        for (int i = 1; i < 16; i++) v.push_back(0);
        run_vec(1, v, 1'b0, 0, "floor_neg");
        v = {255};
        for (int i = 1; i < 16; i++) v.push_back(0);
        run_vec(1, v, 1'b0, 5, "floor_pos");

        beat(0, 1000);
        beat(0, 1000);
        check("mid.busy", busyw[0], 1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        check("mid_rst.busy", busyw[0], 0);
        run_vec(0, '{1, 2, 3, 4}, 1'b0, 0, "after_rst");

        beat(0, 7); beat(0, 7); beat(0, 7); beat(0, 7);
        check("out_rst.pre_valid", avalid[0], 1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        check("out_rst.valid", avalid[0], 0);
        check("out_rst.dout", dout[0], 0);
        check("out_rst.ready", pready[0], 1);

        for (int r = 0; r < 8; r++) begin
            rand_vec(0, -4096, 4095, v);
            run_vec(0, v, 1'b1, $urandom_range(0, 5), $sformatf("rand_a%0d", r));
            rand_vec(1, -4096, 4095, v);
            run_vec(1, v, 1'b1, $urandom_range(0, 5), $sformatf("rand_b%0d", r));
            rand_vec(2, -4096, 4095, v);
            run_vec(2, v, 1'b1, $urandom_range(0, 3), $sformatf("len1_%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
